mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
Multi-cycle control unit for the MIPS-subset core. It sequences the program counter, instruction register, register file, ALU and data memory through fetch/decode/execute/memory/writeback phases. It is a Moore FSM, except for the branch PC-write, which depends on the ALU Zero flag. It also keeps a retired-instruction counter for debug and bench checking.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
Clk  in  1  clock; state register updates on posedge
Rst  in  1  reset, asynchronous, active-high
Op  in  6  instruction[31:26] from IR
Funct  in  6  instruction[5:0] from IR
Zero  in  1  ALU zero flag, valid in BEQ state
PCWrite  out  1  PC load enable
PCSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
IRWrite  out  1  IR load enable
RegWrite  out  1  register-file write enable
RegDst  out  1  0 rt, 1 rd
MemtoReg  out  1  0 ALUOut, 1 MDR
MemRead  out  1  data-memory read
MemWrite  out  1  data-memory write
ALUSrcA  out  1  0 PC, 1 A
ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
ExtOp  out  1  1 sign-extend, 0 zero-extend
ALUCtrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
State  out  4  current state (debug)
Illegal  out  1  unsupported opcode/funct decoded (ID only)
Icount  out  CNT_W  retired-instruction count

Behaviour:
- Supported: R-type (Op 000000) with add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; beq 000100; j 000010; addi 001000; ori 001101.
- State encoding: IF=0, ID=1, MA=2, LWM=3, LWB=4, SWM=5, REX=6, RWB=7, BEQ=8, J=9, IEX=10, IWB=11. Codes 12-15 are unreachable; if entered, next state is IF.
- Rst high: State=IF and Icount=0 immediately. PCWrite, IRWrite, RegWrite and MemWrite are forced 0 while Rst is high, overriding state decode. Reset mid-instruction abandons the instruction; no counter increment.
- Default for every control output is 0, except ExtOp=1 and ALUCtrl=ADD.
- IF: IRWrite=1, PCWrite=1, PCSrc=00, ALUSrcA=0, ALUSrcB=01, ADD. Next state ID.
- ID: ALUSrcA=0, ALUSrcB=11, ADD, which precomputes the branch target into ALUOut. Next state by Op:
  - lw or sw -> MA
  - R-type -> REX
  - beq -> BEQ
  - j -> J
  - addi or ori -> IEX
  - anything else, including R-type with an unsupported funct -> Illegal=1 (combinational, this cycle only), next IF
- MA: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ADD. lw -> LWM; sw -> SWM.
- LWM: MemRead=1 -> LWB.
- LWB: RegWrite=1, RegDst=0, MemtoReg=1 -> IF.
- SWM: MemWrite=1 -> IF.
- REX: ALUSrcA=1, ALUSrcB=00, ALUCtrl decoded from Funct -> RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0 -> IF.
- IEX: ALUSrcA=1, ALUSrcB=10. addi: ExtOp=1, ADD. ori: ExtOp=0, OR. -> IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0 -> IF.
- BEQ: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCWrite=Zero (Mealy) -> IF.
- J: PCWrite=1, PCSrc=10 -> IF.
- Latency in cycles, counting IF:
  - lw 5
  - sw, R-type, addi, ori 4
  - beq, j 3
  - illegal 2
- Icount increments by 1 on the posedge leaving LWB, SWM, RWB, IWB, BEQ or J. It wraps at 2^CNT_W-1 -> 0. It does not increment on the illegal path.
- Op and Funct are sampled combinationally. IR is stable from ID onward because IRWrite=1 only in IF.

Decomposition:
- Shared package mc_pkg holds:
  - opcode and funct constants
  - state encodings
  - ALUCtrl codes
  - PCSrc and ALUSrcB codes
- One natural sub-module: alu_dec. It is combinational and maps Funct to ALUCtrl, with an illegal-funct flag. mc_ctrl instantiates it for REX and for the ID legality check.

Test Plan:
- Rst pulsed mid-LWM -> State=0 and Icount=0 asynchronously; MemRead/RegWrite low during Rst; fetch restarts at IF after release.
- lw (Op 100011) -> State sequence 0,1,2,3,4,0. MemRead=1 only in state 3. RegWrite=1 with MemtoReg=1 only in state 4. Icount +1.
- R-type slt (Funct 101010) -> sequence 0,1,6,7,0. ALUCtrl=111 in state 6. RegWrite=1 with RegDst=1 in state 7.
- beq with Zero=1, then Zero=0 -> first: PCWrite=1, PCSrc=01 in state 8; second: PCWrite=0. Both take 3 cycles; Icount +2 total.
- ori then addi -> in state 10: ExtOp=0, ALUCtrl=001 for ori; ExtOp=1, ALUCtrl=010 for addi.
- Op 111111, then R-type Funct 000111 -> each: Illegal=1 in ID, next State=0, Icount unchanged.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit.
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_LWM = 4'd3,
    S_LWB = 4'd4,
    S_SWM = 4'd5,
    S_REX = 4'd6,
    S_RWB = 4'd7,
    S_BEQ = 4'd8,
    S_J   = 4'd9,
    S_IEX = 4'd10,
    S_IWB = 4'd11
  } state_t;

  // States whose exit completes an instruction
  function automatic logic is_retire(state_t s);
    return (s == S_LWB) || (s == S_SWM) || (s == S_RWB) ||
           (s == S_IWB) || (s == S_BEQ) || (s == S_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct to ALU operation decoder, flags unsupported funct codes.
module alu_dec
  import mc_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic               illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [OP_W-1:0]    Op,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic [ALU_W-1:0]   ALUCtrl,
  output logic [STATE_W-1:0] State,
  output logic               Illegal,
  output logic [CNT_W-1:0]   Icount
);

  state_t             state, next_state;
  logic [ALU_W-1:0]   funct_alu;
  logic               funct_bad;

  alu_dec u_alu_dec (
    .funct    (Funct),
    .alu_ctrl (funct_alu),
    .illegal  (funct_bad)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IF;
    else     state <= next_state;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)                  Icount <= '0;
    else if (is_retire(state)) Icount <= Icount + CNT_W'(1);
  end

  assign State = state;

  always_comb begin
    next_state = S_IF;
    PCWrite    = 1'b0;
    PCSrc      = PCSRC_ALU;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ExtOp      = 1'b1;
    ALUCtrl    = ALU_ADD;
    Illegal    = 1'b0;
    case (state)
      S_IF: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        next_state = S_ID;
      end
      S_ID: begin
        // ALUOut captures PC + (imm<<2) for a possible branch
        ALUSrcB = SRCB_BRANCH;
        case (Op)
          OP_LW, OP_SW:     next_state = S_MA;
          OP_BEQ:           next_state = S_BEQ;
          OP_J:             next_state = S_J;
          OP_ADDI, OP_ORI:  next_state = S_IEX;
          OP_RTYPE: begin
            if (funct_bad) Illegal    = 1'b1;
            else           next_state = S_REX;
          end
          default:          Illegal    = 1'b1;
        endcase
      end
      S_MA: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = (Op == OP_LW) ? S_LWM : S_SWM;
      end
      S_LWM: begin
        MemRead    = 1'b1;
        next_state = S_LWB;
      end
      S_LWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_SWM: MemWrite = 1'b1;
      S_REX: begin
        ALUSrcA    = 1'b1;
        ALUCtrl    = funct_alu;
        next_state = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_IEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        next_state = S_IWB;
        if (Op == OP_ORI) begin
          ExtOp   = 1'b0;
          ALUCtrl = ALU_OR;
        end
      end
      S_IWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 1'b1;
        ALUCtrl = ALU_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = Zero;
      end
      S_J: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      default: next_state = S_IF;
    endcase
    // Architectural write enables stay quiet while reset is asserted
    if (Rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

endmodule
